// File: rtl/ppl_fetch.sv
// ppl_fetch: IF stage and IF/ID register of a 5-stage MIPS pipeline.
// Owns the PC. Fetches over a variable-latency req/ready instruction port.
// A 1-entry skid buffer holds a word that lands while ID is stalled.
// Redirects from ID (branch / jr / j) honour one branch delay slot.
// Optional feature macro: PPL_FETCH_PERF_EN adds the fetchCnt/stallCnt counters.
module ppl_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [1:0]  pcSrc,
  input  logic        pcContinue,
  input  logic [31:0] bpc,
  input  logic [31:0] rpc,
  input  logic [31:0] jpc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        dValid,
  output logic [31:0] dInst,
  output logic [31:0] dPc4
`ifdef PPL_FETCH_PERF_EN
  ,
  output logic [31:0] fetchCnt,
  output logic [31:0] stallCnt
`endif
);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t      state;
  logic        req_q;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic [31:0] buf_inst;
  logic [31:0] buf_pc4;
  logic        pend;
  logic [31:0] pend_tgt;
  logic [31:0] redir_tgt;
  logic        buf_full;
  logic        done;
  logic        ld;
  logic        fill;
  logic        redir;
  logic        slot_here;

  assign imem_req  = req_q;
  assign imem_addr = pc;
  assign pc4       = pc + 32'd4;

  // The buffer is occupied exactly while the FSM sits in FULL.
  assign buf_full  = (state == S_FULL);
  assign done      = req_q & imem_ready;

  // IF/ID may take a new word when empty or when ID consumes this cycle.
  // pcContinue feeds this combinationally on purpose.
  assign ld        = ~dValid | (pcContinue & dValid);

  // A completing word that IF/ID cannot take goes into the skid buffer.
  assign fill      = done & (~ld | buf_full);

  // ID is consuming a control-transfer instruction this cycle.
  assign redir     = dValid & pcContinue & (pcSrc != 2'b00);

  // The delay slot is already fetched if it sits in the buffer or lands now.
  assign slot_here = buf_full | done;

  // Redirect target selection, sampled in the cycle ID consumes the branch.
  always_comb begin
    redir_tgt = pc4;
    case (pcSrc)
      2'b01:   redir_tgt = bpc;
      2'b10:   redir_tgt = rpc;
      2'b11:   redir_tgt = jpc;
      default: redir_tgt = pc4;
    endcase
  end

  // Fetch FSM: BOOT for one cycle after reset, FETCH issues, FULL holds off.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= S_BOOT;
      req_q <= 1'b0;
    end else begin
      case (state)
        S_BOOT: begin
          state <= S_FETCH;
          req_q <= 1'b1;
        end
        S_FETCH: begin
          if (fill) begin
            state <= S_FULL;
            req_q <= 1'b0;
          end else begin
            req_q <= 1'b1;
          end
        end
        S_FULL: begin
          if (ld && !fill) begin
            state <= S_FETCH;
            req_q <= 1'b1;
          end else begin
            req_q <= 1'b0;
          end
        end
        default: begin
          state <= S_BOOT;
          req_q <= 1'b0;
        end
      endcase
    end
  end

  // Skid buffer capture of a completing word that IF/ID cannot accept.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      buf_inst <= 32'h0;
      buf_pc4  <= 32'h0;
    end else if (fill) begin
      buf_inst <= imem_rdata;
      buf_pc4  <= pc4;
    end
  end

  // IF/ID register: buffered word first, then a fresh completion, else bubble.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      dValid <= 1'b0;
      dInst  <= 32'h0;
      dPc4   <= 32'h0;
    end else if (ld) begin
      if (buf_full) begin
        dValid <= 1'b1;
        dInst  <= buf_inst;
        dPc4   <= buf_pc4;
      end else if (done) begin
        dValid <= 1'b1;
        dInst  <= imem_rdata;
        dPc4   <= pc4;
      end else begin
        dValid <= 1'b0;
      end
    end
  end

  // PC update: immediate redirect when the delay slot is already in hand,
  // otherwise remember the target and apply it when the delay slot lands.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pc       <= RESET_PC;
      pend     <= 1'b0;
      pend_tgt <= 32'h0;
    end else if (redir && slot_here) begin
      pc <= redir_tgt;
    end else if (redir) begin
      pend     <= 1'b1;
      pend_tgt <= redir_tgt;
    end else if (done) begin
      pc   <= pend ? pend_tgt : pc4;
      pend <= 1'b0;
    end
  end

`ifdef PPL_FETCH_PERF_EN
  // Performance counters: completed fetches and ID stall cycles, wrapping.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      fetchCnt <= 32'h0;
      stallCnt <= 32'h0;
    end else begin
      if (done)
        fetchCnt <= fetchCnt + 32'd1;
      if (dValid && !pcContinue)
        stallCnt <= stallCnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ppl_fetch.sv
// tb_ppl_fetch: directed scenarios plus a randomized run checked against a
// program-order model (which address ID must see next, including delay slots).
// Instruction memory returns the address as the instruction word.
module tb_ppl_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clock;
  logic        resetn;
  logic [1:0]  pcSrc;
  logic        pcContinue;
  logic [31:0] bpc;
  logic [31:0] rpc;
  logic [31:0] jpc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        dValid;
  logic [31:0] dInst;
  logic [31:0] dPc4;
`ifdef PPL_FETCH_PERF_EN
  logic [31:0] fetchCnt;
  logic [31:0] stallCnt;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int n_comp   = 0;
  int n_stall  = 0;

  assign imem_rdata = imem_addr;

  ppl_fetch #(.RESET_PC(RESET_PC)) dut (
    .clock(clock),
    .resetn(resetn),
    .pcSrc(pcSrc),
    .pcContinue(pcContinue),
    .bpc(bpc),
    .rpc(rpc),
    .jpc(jpc),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ready(imem_ready),
    .imem_rdata(imem_rdata),
    .dValid(dValid),
    .dInst(dInst),
    .dPc4(dPc4)
`ifdef PPL_FETCH_PERF_EN
    ,
    .fetchCnt(fetchCnt),
    .stallCnt(stallCnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One clock cycle; inputs were set at the previous negedge, outputs are
  // sampled at the next negedge. Tracks handshakes and stall cycles seen.
  task automatic tick();
    if (imem_req && imem_ready) n_comp++;
    if (dValid && !pcContinue) n_stall++;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic apply_reset();
    resetn     = 1'b0;
    pcSrc      = 2'b00;
    pcContinue = 1'b1;
    bpc        = 32'h0;
    rpc        = 32'h0;
    jpc        = 32'h0;
    imem_ready = 1'b0;
    @(negedge clock);
    @(negedge clock);
    resetn  = 1'b1;
    n_comp  = 0;
    n_stall = 0;
  endtask

  function automatic logic [31:0] pick_tgt();
    logic [31:0] t;
    if (($urandom % 8) == 0) t = 32'hFFFF_FFF8;
    else t = 32'($urandom_range(0, 1023)) << 2;
    return t;
  endfunction

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if (imem_req !== 1'b0 || imem_addr !== RESET_PC || dValid !== 1'b0 ||
        dInst !== 32'h0 || dPc4 !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_state: req=%b addr=%h dValid=%b dInst=%h dPc4=%h, want 0/%h/0/0/0",
               imem_req, imem_addr, dValid, dInst, dPc4, RESET_PC);
    end
  endtask

  task automatic test_stream();
    apply_reset();
    imem_ready = 1'b1;
    tick();
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || dValid !== 1'b0) begin
      n_errors++;
      $display("FAIL stream_boot: req=%b addr=%h dValid=%b, want 1/0/0", imem_req, imem_addr, dValid);
    end
    tick();
    n_checks++;
    if (dValid !== 1'b1 || dInst !== 32'h0 || dPc4 !== 32'h4) begin
      n_errors++;
      $display("FAIL stream_first: dValid=%b dInst=%h dPc4=%h, want 1/0/4", dValid, dInst, dPc4);
    end
    for (int k = 1; k <= 5; k++) begin
      n_checks++;
      if (imem_addr !== 32'(4 * k) || dInst !== 32'(4 * (k - 1))) begin
        n_errors++;
        $display("FAIL stream_seq: addr=%h dInst=%h, want %h/%h", imem_addr, dInst, 32'(4 * k), 32'(4 * (k - 1)));
      end
      tick();
    end
  endtask

  task automatic test_wait();
    apply_reset();
    imem_ready = 1'b1;
    for (int i = 0; i < 10 && imem_addr !== 32'h8; i++) tick();
    n_checks++;
    if (imem_addr !== 32'h8) begin
      n_errors++;
      $display("FAIL wait_reach: addr=%h, want 00000008", imem_addr);
    end
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (imem_addr !== 32'h8 || imem_req !== 1'b1 || dValid !== 1'b0) begin
        n_errors++;
        $display("FAIL wait_hold: addr=%h req=%b dValid=%b, want 8/1/0", imem_addr, imem_req, dValid);
      end
    end
    imem_ready = 1'b1;
    tick();
    n_checks++;
    if (dValid !== 1'b1 || dInst !== 32'h8) begin
      n_errors++;
      $display("FAIL wait_done: dValid=%b dInst=%h, want 1/8", dValid, dInst);
    end
  endtask

  task automatic test_stall();
    apply_reset();
    imem_ready = 1'b1;
    tick();
    tick();
    pcContinue = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (dValid !== 1'b1 || dInst !== 32'h0 || dPc4 !== 32'h4 || imem_req !== 1'b0) begin
        n_errors++;
        $display("FAIL stall_frozen: dValid=%b dInst=%h dPc4=%h req=%b, want 1/0/4/0",
                 dValid, dInst, dPc4, imem_req);
      end
    end
    pcContinue = 1'b1;
    tick();
    n_checks++;
    if (dValid !== 1'b1 || dInst !== 32'h4 || dPc4 !== 32'h8) begin
      n_errors++;
      $display("FAIL stall_drain: dValid=%b dInst=%h dPc4=%h, want 1/4/8", dValid, dInst, dPc4);
    end
    tick();
    n_checks++;
    if (dValid !== 1'b1 || dInst !== 32'h8) begin
      n_errors++;
      $display("FAIL stall_next: dValid=%b dInst=%h, want 1/8", dValid, dInst);
    end
`ifdef PPL_FETCH_PERF_EN
    n_checks++;
    if (stallCnt !== 32'd4 || fetchCnt !== 32'(n_comp)) begin
      n_errors++;
      $display("FAIL stall_perf: stallCnt=%0d fetchCnt=%0d, want 4/%0d", stallCnt, fetchCnt, n_comp);
    end
`endif
  endtask

  task automatic test_branch_pending();
    logic [31:0] seq[$];
    logic [31:0] want[4];
    want[0] = 32'h10; want[1] = 32'h14; want[2] = 32'h40; want[3] = 32'h44;
    apply_reset();
    imem_ready = 1'b1;
    for (int i = 0; i < 20 && !(dValid === 1'b1 && dInst === 32'h10); i++) tick();
    imem_ready = 1'b0;
    pcSrc = 2'b01;
    bpc = 32'h40;
    if (dValid === 1'b1) seq.push_back(dInst);
    tick();
    pcSrc = 2'b00;
    bpc = 32'hDEAD_BEE0;
    if (dValid === 1'b1) seq.push_back(dInst);
    tick();
    imem_ready = 1'b1;
    for (int i = 0; i < 20 && seq.size() < 4; i++) begin
      if (dValid === 1'b1) begin
        if (dInst === 32'h14) begin
          n_checks++;
          if (imem_addr !== 32'h40) begin
            n_errors++;
            $display("FAIL branch_addr: addr=%h, want 00000040", imem_addr);
          end
        end
        seq.push_back(dInst);
      end
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (i >= seq.size()) begin
        n_errors++;
        $display("FAIL branch_seq[%0d]: missing, want %h", i, want[i]);
      end else if (seq[i] !== want[i]) begin
        n_errors++;
        $display("FAIL branch_seq[%0d]: got %h, want %h", i, seq[i], want[i]);
      end
    end
  endtask

  task automatic test_jr_full();
    apply_reset();
    imem_ready = 1'b1;
    for (int i = 0; i < 20 && !(dValid === 1'b1 && dInst === 32'h10); i++) tick();
    pcContinue = 1'b0;
    tick();
    n_checks++;
    if (imem_req !== 1'b0 || dInst !== 32'h10) begin
      n_errors++;
      $display("FAIL jr_fill: req=%b dInst=%h, want 0/10", imem_req, dInst);
    end
    pcContinue = 1'b1;
    pcSrc = 2'b10;
    rpc = 32'h100;
    tick();
    pcSrc = 2'b00;
    rpc = 32'h0;
    n_checks++;
    if (dInst !== 32'h14 || dValid !== 1'b1 || imem_addr !== 32'h100 || imem_req !== 1'b1) begin
      n_errors++;
      $display("FAIL jr_slot: dInst=%h dValid=%b addr=%h req=%b, want 14/1/100/1",
               dInst, dValid, imem_addr, imem_req);
    end
    tick();
    n_checks++;
    if (dInst !== 32'h100 || dPc4 !== 32'h104) begin
      n_errors++;
      $display("FAIL jr_target: dInst=%h dPc4=%h, want 100/104", dInst, dPc4);
    end
  endtask

  task automatic test_reset_midwait();
    apply_reset();
    imem_ready = 1'b1;
    tick(); tick(); tick();
    imem_ready = 1'b0;
    tick(); tick();
`ifdef PPL_FETCH_PERF_EN
    n_checks++;
    if (fetchCnt !== 32'(n_comp)) begin
      n_errors++;
      $display("FAIL midwait_perf: fetchCnt=%0d, want %0d", fetchCnt, n_comp);
    end
`endif
    #2;
    resetn = 1'b0;
    imem_ready = 1'b1;
    #1;
    n_checks++;
    if (imem_req !== 1'b0 || imem_addr !== RESET_PC || dValid !== 1'b0 ||
        dInst !== 32'h0 || dPc4 !== 32'h0) begin
      n_errors++;
      $display("FAIL midwait_clear: req=%b addr=%h dValid=%b dInst=%h dPc4=%h, want all zero",
               imem_req, imem_addr, dValid, dInst, dPc4);
    end
`ifdef PPL_FETCH_PERF_EN
    n_checks++;
    if (fetchCnt !== 32'h0 || stallCnt !== 32'h0) begin
      n_errors++;
      $display("FAIL midwait_perf_clear: fetchCnt=%0d stallCnt=%0d, want 0/0", fetchCnt, stallCnt);
    end
`endif
    @(negedge clock);
    @(negedge clock);
    resetn = 1'b1;
    n_comp = 0;
    n_stall = 0;
    tick();
    n_checks++;
    if (imem_addr !== RESET_PC || imem_req !== 1'b1 || dValid !== 1'b0) begin
      n_errors++;
      $display("FAIL midwait_restart: addr=%h req=%b dValid=%b, want %h/1/0", imem_addr, imem_req, dValid, RESET_PC);
    end
    tick();
    n_checks++;
    if (dValid !== 1'b1 || dInst !== RESET_PC || dPc4 !== RESET_PC + 32'd4) begin
      n_errors++;
      $display("FAIL midwait_first: dValid=%b dInst=%h dPc4=%h, want 1/%h/%h",
               dValid, dInst, dPc4, RESET_PC, RESET_PC + 32'd4);
    end
  endtask

  // Random ready/stall/redirect traffic. The model only knows program order:
  // each consumed instruction is followed by +4, except that a taken
  // control transfer is followed by its delay slot and then its target.
  task automatic test_random();
    logic [31:0] exp_pc;
    logic [31:0] tgt;
    logic [31:0] addr_prev;
    bit          slot_next;
    bit          wait_prev;
    int          consumed;
    exp_pc = RESET_PC;
    tgt = 32'h0;
    addr_prev = 32'h0;
    slot_next = 0;
    wait_prev = 0;
    consumed = 0;
    apply_reset();
    for (int cyc = 0; cyc < 4000 && consumed < 300; cyc++) begin
      if (wait_prev) begin
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== addr_prev) begin
          n_errors++;
          $display("FAIL rand_hold: req=%b addr=%h, want 1/%h", imem_req, imem_addr, addr_prev);
        end
      end
      imem_ready = ($urandom % 3) != 0;
      pcContinue = ($urandom % 4) != 0;
      pcSrc = 2'($urandom % 4);
      bpc = pick_tgt();
      rpc = pick_tgt();
      jpc = pick_tgt();
      if (dValid === 1'b1 && pcContinue) begin
        if (slot_next || ($urandom % 2) == 0) pcSrc = 2'b00;
        n_checks++;
        if (dInst !== exp_pc || dPc4 !== exp_pc + 32'd4) begin
          n_errors++;
          $display("FAIL rand_order: dInst=%h dPc4=%h, want %h/%h", dInst, dPc4, exp_pc, exp_pc + 32'd4);
        end
        if (slot_next) begin
          exp_pc = tgt;
          slot_next = 0;
        end else if (pcSrc != 2'b00) begin
          tgt = (pcSrc == 2'b01) ? bpc : (pcSrc == 2'b10) ? rpc : jpc;
          exp_pc = exp_pc + 32'd4;
          slot_next = 1;
        end else begin
          exp_pc = exp_pc + 32'd4;
        end
        consumed++;
      end
      wait_prev = (imem_req === 1'b1) && !imem_ready;
      addr_prev = imem_addr;
      tick();
    end
    n_checks++;
    if (consumed < 300) begin
      n_errors++;
      $display("FAIL rand_progress: consumed %0d, want 300 within 4000 cycles", consumed);
    end
    pcSrc = 2'b00;
`ifdef PPL_FETCH_PERF_EN
    n_checks++;
    if (fetchCnt !== 32'(n_comp) || stallCnt !== 32'(n_stall)) begin
      n_errors++;
      $display("FAIL rand_perf: fetchCnt=%0d stallCnt=%0d, want %0d/%0d", fetchCnt, stallCnt, n_comp, n_stall);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_stream();
    test_wait();
    test_stall();
    test_branch_pending();
    test_jr_full();
    test_reset_midwait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
